// File: rtl/load_use_scoreboard_if.sv
// Issue/check/status bundle between decode-issue logic (master) and the load-use scoreboard (slave).
// CW is derived from MAX_LAT so issue_lat can carry every trackable latency.
interface load_use_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int NUM_RD   = 2,
  parameter int MAX_LAT  = 3
);
  localparam int CW = $clog2(MAX_LAT + 1);

  logic                    issue_valid;
  logic                    issue_we;
  logic [REG_W-1:0]        issue_rd;
  logic [CW-1:0]           issue_lat;
  logic [NUM_RD*REG_W-1:0] chk_addr;
  logic [NUM_RD-1:0]       chk_used;
  logic                    mem_stall;
  logic                    flush;
  logic                    stall;
  logic [NUM_RD-1:0]       hazard_mask;
  logic [NUM_REGS-1:0]     busy;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, chk_addr, chk_used, mem_stall, flush,
    input  stall, hazard_mask, busy
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, chk_addr, chk_used, mem_stall, flush,
    output stall, hazard_mask, busy
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Per-register countdown timers that hold a consumer until every producer it reads is forwardable.
// Outputs are combinational on current counters; issues are seen by checks one cycle later. LUS_ZERO_REG_EN hardwires r0.
module load_use_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int NUM_RD   = 2,
  parameter int MAX_LAT  = 3
) (
  input logic                  clk,
  input logic                  rst,
  load_use_scoreboard_if.slave bus
);
  localparam int CW  = $clog2(MAX_LAT + 1);
  localparam int CW1 = CW + 1;

  logic [CW-1:0]     cnt_q   [NUM_REGS];
  logic [CW-1:0]     cnt_d   [NUM_REGS];
  logic [CW-1:0]     cnt_dec [NUM_REGS];
  logic [NUM_RD-1:0] hazard;
  logic              issue_acc;
  logic [CW:0]       lat_ext;
  logic [CW-1:0]     lat_clamped;

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hazard[i] = bus.chk_used[i] && (cnt_q[bus.chk_addr[i*REG_W +: REG_W]] != '0) && !bus.flush;
    end
  end

  // Stalled consumers block the issue slot, so a producer never lands while the check is held.
  always_comb begin
    lat_ext     = {1'b0, bus.issue_lat};
    lat_clamped = (lat_ext > CW1'(MAX_LAT)) ? CW'(MAX_LAT) : bus.issue_lat;
    issue_acc   = bus.issue_valid && bus.issue_we && (hazard == '0) && !bus.mem_stall && !bus.flush;
`ifdef LUS_ZERO_REG_EN
    issue_acc   = issue_acc && (bus.issue_rd != '0);
`endif
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_dec[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else if (bus.mem_stall) begin
        cnt_d[r] = cnt_q[r];
      end else if (issue_acc && (bus.issue_rd == REG_W'(r))) begin
        // WAW: keep whichever producer finishes later.
        cnt_d[r] = (cnt_dec[r] > lat_clamped) ? cnt_dec[r] : lat_clamped;
      end else begin
        cnt_d[r] = cnt_dec[r];
      end
    end
`ifdef LUS_ZERO_REG_EN
    cnt_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    bus.busy = '0;
    for (int r = 0; r < NUM_REGS; r++) bus.busy[r] = (cnt_q[r] != '0);
  end

  assign bus.hazard_mask = hazard;
  assign bus.stall       = |hazard;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard: directed scenarios plus a randomized run against a ready-time model.
// The model records, per register, the absolute cycle at which its value becomes forwardable.
module tb_load_use_scoreboard;
  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int NUM_RD   = 2;
  localparam int MAX_LAT  = 3;
  localparam int CW       = $clog2(MAX_LAT + 1);

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   ready_at [NUM_REGS];
  int   now = 0;

  load_use_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_RD(NUM_RD), .MAX_LAT(MAX_LAT)) bus ();

  load_use_scoreboard #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_RD(NUM_RD), .MAX_LAT(MAX_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_cnt(input int r);
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic logic [NUM_RD-1:0] exp_hazard();
    logic [NUM_RD-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      h[i] = bus.chk_used[i] && (m_cnt(int'(bus.chk_addr[i*REG_W +: REG_W])) > 0) && !bus.flush;
    end
    return h;
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_busy();
    logic [NUM_REGS-1:0] b;
    b = '0;
    for (int r = 0; r < NUM_REGS; r++) b[r] = (m_cnt(r) > 0);
    return b;
  endfunction

  task automatic model_edge();
    bit acc;
    int lat;
    int rd;
    acc = bus.issue_valid && bus.issue_we && (exp_hazard() == '0) && !bus.mem_stall && !bus.flush;
    rd  = int'(bus.issue_rd);
`ifdef LUS_ZERO_REG_EN
    if (rd == 0) acc = 1'b0;
`endif
    lat = int'(bus.issue_lat);
    if (lat > MAX_LAT) lat = MAX_LAT;
    if (rst || bus.flush) begin
      foreach (ready_at[r]) ready_at[r] = 0;
    end else if (bus.mem_stall) begin
      foreach (ready_at[r]) if (ready_at[r] > now) ready_at[r] = ready_at[r] + 1;
    end else if (acc && (now + 1 + lat > ready_at[rd])) begin
      ready_at[rd] = now + 1 + lat;
    end
    now = now + 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_issue(input logic v, input logic [REG_W-1:0] rd, input logic [CW-1:0] lat);
    bus.issue_valid = v;
    bus.issue_we    = v;
    bus.issue_rd    = rd;
    bus.issue_lat   = lat;
  endtask

  task automatic set_chk(input logic [REG_W-1:0] a0, input logic [REG_W-1:0] a1, input logic [NUM_RD-1:0] used);
    bus.chk_addr = {a1, a0};
    bus.chk_used = used;
  endtask

  task automatic set_ctl(input logic r, input logic ms, input logic fl);
    rst           = r;
    bus.mem_stall = ms;
    bus.flush     = fl;
  endtask

  task automatic idle();
    set_issue(1'b0, '0, '0);
    set_chk('0, '0, '0);
    set_ctl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (MAX_LAT + 1) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_ctl(1'b1, 1'b0, 1'b0);
    set_issue(1'b1, REG_W'(2), CW'(3));
    tick();
    idle();
    set_chk(REG_W'(2), REG_W'(2), 2'b11);
    settle();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    tests++; if (bus.hazard_mask !== 2'b00) begin fails++; $display("FAIL reset_hazard: got %b want 00", bus.hazard_mask); end
    tests++; if (bus.busy !== 8'h00) begin fails++; $display("FAIL reset_busy: got %h want 00", bus.busy); end
    tick();
  endtask

  task automatic test_load_use();
    drain();
    set_issue(1'b1, REG_W'(3), CW'(1));
    settle();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_use_no_bypass: got %b want 0", bus.stall); end
    tick();
    idle();
    set_chk(REG_W'(3), REG_W'(0), 2'b01);
    settle();
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL load_use_stall_c1: got %b want 1", bus.stall); end
    tests++; if (bus.busy !== 8'h08) begin fails++; $display("FAIL load_use_busy_c1: got %h want 08", bus.busy); end
    tick();
    settle();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_use_stall_c2: got %b want 0", bus.stall); end
    tests++; if (bus.busy !== 8'h00) begin fails++; $display("FAIL load_use_busy_c2: got %h want 00", bus.busy); end
    tick();
  endtask

  task automatic test_multi_cycle();
    drain();
    set_issue(1'b1, REG_W'(5), CW'(3));
    tick();
    idle();
    set_chk(REG_W'(5), REG_W'(0), 2'b01);
    for (int k = 1; k <= 4; k++) begin
      settle();
      tests++; if (bus.stall !== (k <= 3)) begin fails++; $display("FAIL multi_stall_c%0d: got %b want %b", k, bus.stall, (k <= 3)); end
      tests++; if (bus.busy[5] !== (k <= 3)) begin fails++; $display("FAIL multi_busy5_c%0d: got %b want %b", k, bus.busy[5], (k <= 3)); end
      tick();
    end
  endtask

  task automatic test_waw();
    drain();
    set_issue(1'b1, REG_W'(2), CW'(3));
    tick();
    set_issue(1'b1, REG_W'(2), CW'(1));
    tick();
    idle();
    set_chk(REG_W'(2), REG_W'(0), 2'b01);
    for (int k = 2; k <= 4; k++) begin
      settle();
      tests++; if (bus.stall !== (k <= 3)) begin fails++; $display("FAIL waw_stall_c%0d: got %b want %b", k, bus.stall, (k <= 3)); end
      tick();
    end
  endtask

  task automatic test_used_mask();
    drain();
    set_issue(1'b1, REG_W'(4), CW'(3));
    tick();
    idle();
    tick();
    set_chk(REG_W'(0), REG_W'(4), 2'b01);
    settle();
    tests++; if (bus.hazard_mask !== 2'b00) begin fails++; $display("FAIL used_mask_01: got %b want 00", bus.hazard_mask); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL used_stall_01: got %b want 0", bus.stall); end
    set_chk(REG_W'(0), REG_W'(4), 2'b11);
    #1;
    tests++; if (bus.hazard_mask !== 2'b10) begin fails++; $display("FAIL used_mask_11: got %b want 10", bus.hazard_mask); end
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL used_stall_11: got %b want 1", bus.stall); end
    set_chk(REG_W'(4), REG_W'(4), 2'b11);
    #1;
    tests++; if (bus.hazard_mask !== 2'b11) begin fails++; $display("FAIL used_dup_ports: got %b want 11", bus.hazard_mask); end
    tick();
  endtask

  task automatic test_mem_stall_flush();
    drain();
    set_issue(1'b1, REG_W'(6), CW'(3));
    tick();
    idle();
    tick();
    for (int k = 0; k < 3; k++) begin
      set_ctl(1'b0, 1'b1, 1'b0);
      set_issue(1'b1, REG_W'(1), CW'(3));
      settle();
      tests++; if (bus.busy !== 8'h40) begin fails++; $display("FAIL memstall_busy_%0d: got %h want 40", k, bus.busy); end
      tick();
    end
    idle();
    set_chk(REG_W'(6), REG_W'(1), 2'b11);
    settle();
    tests++; if (bus.hazard_mask !== 2'b01) begin fails++; $display("FAIL memstall_held: got %b want 01", bus.hazard_mask); end
    tick();
    set_ctl(1'b0, 1'b0, 1'b1);
    set_issue(1'b1, REG_W'(7), CW'(3));
    settle();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
    tests++; if (bus.busy !== 8'h40) begin fails++; $display("FAIL flush_busy_pre: got %h want 40", bus.busy); end
    tick();
    idle();
    settle();
    tests++; if (bus.busy !== 8'h00) begin fails++; $display("FAIL flush_busy_post: got %h want 00", bus.busy); end
    tick();
  endtask

  task automatic test_clamp();
    drain();
    set_issue(1'b1, REG_W'(1), '1);
    tick();
    idle();
    set_chk(REG_W'(1), REG_W'(1), 2'b10);
    for (int k = 1; k <= MAX_LAT + 1; k++) begin
      settle();
      tests++; if (bus.stall !== (k <= MAX_LAT)) begin fails++; $display("FAIL clamp_stall_c%0d: got %b want %b", k, bus.stall, (k <= MAX_LAT)); end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    drain();
    set_issue(1'b1, REG_W'(0), CW'(3));
    tick();
    idle();
    set_chk(REG_W'(0), REG_W'(0), 2'b11);
    settle();
`ifdef LUS_ZERO_REG_EN
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL zero_reg_stall: got %b want 0", bus.stall); end
    tests++; if (bus.busy[0] !== 1'b0) begin fails++; $display("FAIL zero_reg_busy: got %b want 0", bus.busy[0]); end
`else
    tests++; if (bus.hazard_mask !== 2'b11) begin fails++; $display("FAIL r0_hazard: got %b want 11", bus.hazard_mask); end
    tests++; if (bus.busy !== 8'h01) begin fails++; $display("FAIL r0_busy: got %h want 01", bus.busy); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    drain();
    set_issue(1'b1, REG_W'(5), CW'(3));
    tick();
    idle();
    set_ctl(1'b1, 1'b0, 1'b0);
    tick();
    idle();
    set_chk(REG_W'(5), REG_W'(5), 2'b11);
    settle();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_mid_stall: got %b want 0", bus.stall); end
    tests++; if (bus.busy !== 8'h00) begin fails++; $display("FAIL reset_mid_busy: got %h want 00", bus.busy); end
    tick();
  endtask

  task automatic test_random();
    idle();
    set_ctl(1'b1, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < 400; n++) begin
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_we    = ($urandom_range(0, 3) != 0);
      bus.issue_rd    = REG_W'($urandom_range(0, NUM_REGS - 1));
      bus.issue_lat   = CW'($urandom_range(0, (1 << CW) - 1));
      bus.chk_addr    = (NUM_RD*REG_W)'($urandom);
      bus.chk_used    = NUM_RD'($urandom);
      set_ctl(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
      settle();
      tests++; if (bus.hazard_mask !== exp_hazard()) begin fails++; $display("FAIL rand_hazard n=%0d: got %b want %b", n, bus.hazard_mask, exp_hazard()); end
      tests++; if (bus.stall !== |exp_hazard()) begin fails++; $display("FAIL rand_stall n=%0d: got %b want %b", n, bus.stall, |exp_hazard()); end
      tests++; if (bus.busy !== exp_busy()) begin fails++; $display("FAIL rand_busy n=%0d: got %h want %h", n, bus.busy, exp_busy()); end
      tick();
    end
  endtask

  initial begin
    foreach (ready_at[r]) ready_at[r] = 0;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_multi_cycle();
    test_waw();
    test_used_mask();
    test_mem_stall_flush();
    test_clamp();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
